syn_adc_rx: RTL and testbench

//  I2S capture receiver for the codec ADC path; the receive-side counterpart of the DAC PCM serializer.

---
 rtl/syn_audio_pkg.sv | 16 +
 rtl/syn_adc_sync.sv | 34 +++
 rtl/syn_adc_rx.sv | 133 +++++++++++++
 tb/tb_syn_adc_rx.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/syn_audio_pkg.sv
// Shared audio-path types: PCM frame layout, word-length select and the ADC capture FSM states.
package syn_audio_pkg;

  typedef enum logic {BPS_16 = 1'b0, BPS_32 = 1'b1} bps_t;

  typedef struct packed {
    logic [31:0] lchnnl;
    logic [31:0] rchnnl;
  } pcm_data_t;

  typedef enum logic [1:0] {ADC_SYNC, ADC_LCH, ADC_RCH} adc_rx_fsm_t;

  localparam logic [5:0] BPS16_BITS = 6'd16;
  localparam logic [5:0] BPS32_BITS = 6'd32;

endpackage

// File: rtl/syn_adc_sync.sv
// Brings the codec BCLK/LRC/DAT pins into clk_ir and flags each BCLK rise together with
// the LRC and DAT levels that belong to that rise.
module syn_adc_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_ir,
  input  logic       rst_ih,
  input  logic [2:0] pad,
  output logic       bclk_rise_p0,
  output logic       lrc_p0,
  output logic       dat_p0
);

  logic [SYNC_STAGES-1:0][2:0] sync_q;
  logic                        bclk_prev;

  always_ff @(posedge clk_ir or posedge rst_ih) begin
    if (rst_ih) begin
      sync_q       <= '0;
      bclk_prev    <= 1'b0;
      bclk_rise_p0 <= 1'b0;
      lrc_p0       <= 1'b0;
      dat_p0       <= 1'b0;
    end else begin
      sync_q       <= {sync_q[SYNC_STAGES-2:0], pad};
      bclk_prev    <= sync_q[SYNC_STAGES-1][2];
      // stage boundary p0: strobe and the LRC/DAT levels it qualifies leave together
      bclk_rise_p0 <= sync_q[SYNC_STAGES-1][2] & ~bclk_prev;
      lrc_p0       <= sync_q[SYNC_STAGES-1][1];
      dat_p0       <= sync_q[SYNC_STAGES-1][0];
    end
  end

endmodule

// File: rtl/syn_adc_rx.sv
// I2S capture receiver: deserializes MSB-first L/R words from the codec ADC pins and hands
// one stereo pcm_data_t per frame to the consumer over valid/ready.
module syn_adc_rx
  import syn_audio_pkg::*;
#(
  parameter int   SYNC_STAGES  = 2,
  parameter logic LRC_LEFT_LVL = 1'b0
) (
  input  logic      clk_ir,
  input  logic      rst_ih,
  input  logic      en_i,
  input  bps_t      bps_i,
  input  logic      adc_bclk_i,
  input  logic      adc_lrc_i,
  input  logic      adc_dat_i,
  output pcm_data_t pcm_data_o,
  output logic      pcm_valid_o,
  input  logic      pcm_ready_i,
  output logic      ovrflw_o,
  output logic      short_o,
  input  logic      clr_err_i
);

  logic        bclk_rise_p0, lrc_p0, dat_p0;
  adc_rx_fsm_t state;
  logic [5:0]  n_bits, cnt;
  logic [31:0] shreg, l_word;
  logic        lrc_last;
  pcm_data_t   frame_p1;
  logic        vld_p1;
  logic        lrc_chg, shift_en, short_evt, ovf_evt;

  // MSB-align a possibly short word; 16-bit words are sign-extended to 32 bits.
  function automatic logic [31:0] align_word(input logic [31:0] sh, input logic [5:0] n_got,
                                             input logic [5:0] n_want);
    logic [31:0] w;
    w = sh << (n_want - n_got);
    if (n_want == BPS16_BITS) w = {{16{w[15]}}, w[15:0]};
    return w;
  endfunction

  syn_adc_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_ir      (clk_ir),
    .rst_ih      (rst_ih),
    .pad         ({adc_bclk_i, adc_lrc_i, adc_dat_i}),
    .bclk_rise_p0(bclk_rise_p0),
    .lrc_p0      (lrc_p0),
    .dat_p0      (dat_p0)
  );

  assign lrc_chg   = bclk_rise_p0 & (lrc_p0 != lrc_last);
  assign shift_en  = bclk_rise_p0 & ~lrc_chg & (cnt < n_bits);
  assign short_evt = en_i & lrc_chg & (state != ADC_SYNC) & (cnt < n_bits);
  assign ovf_evt   = vld_p1 & pcm_valid_o & ~pcm_ready_i;

  // stage boundary p1: deserializer and framing FSM
  always_ff @(posedge clk_ir or posedge rst_ih) begin
    if (rst_ih) begin
      state    <= ADC_SYNC;
      n_bits   <= '0;
      cnt      <= '0;
      shreg    <= '0;
      l_word   <= '0;
      lrc_last <= 1'b0;
      frame_p1 <= '0;
      vld_p1   <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      if (bclk_rise_p0) lrc_last <= lrc_p0;
      if (!en_i) begin
        state <= ADC_SYNC;
        cnt   <= '0;
        shreg <= '0;
      end else begin
        case (state)
          ADC_SYNC: begin
            if (lrc_chg && (lrc_p0 == LRC_LEFT_LVL)) begin
              state  <= ADC_LCH;
              n_bits <= (bps_i == BPS_32) ? BPS32_BITS : BPS16_BITS;
              cnt    <= '0;
              shreg  <= '0;
            end
          end
          ADC_LCH: begin
            if (lrc_chg) begin
              l_word <= align_word(shreg, cnt, n_bits);
              cnt    <= '0;
              shreg  <= '0;
              state  <= ADC_RCH;
            end else if (shift_en) begin
              shreg <= {shreg[30:0], dat_p0};
              cnt   <= cnt + 6'd1;
            end
          end
          ADC_RCH: begin
            if (lrc_chg) begin
              frame_p1.lchnnl <= l_word;
              frame_p1.rchnnl <= align_word(shreg, cnt, n_bits);
              vld_p1          <= 1'b1;
              cnt             <= '0;
              shreg           <= '0;
              state           <= ADC_LCH;
            end else if (shift_en) begin
              shreg <= {shreg[30:0], dat_p0};
              cnt   <= cnt + 6'd1;
            end
          end
          default: state <= ADC_SYNC;
        endcase
      end
    end
  end

  // stage boundary p2: output holding register; a frame arriving while the old one is stuck is dropped
  always_ff @(posedge clk_ir or posedge rst_ih) begin
    if (rst_ih) begin
      pcm_data_o  <= '0;
      pcm_valid_o <= 1'b0;
      ovrflw_o    <= 1'b0;
      short_o     <= 1'b0;
    end else begin
      if (vld_p1 && (!pcm_valid_o || pcm_ready_i)) begin
        pcm_data_o  <= frame_p1;
        pcm_valid_o <= 1'b1;
      end else if (pcm_valid_o && pcm_ready_i) begin
        pcm_valid_o <= 1'b0;
      end
      ovrflw_o <= ovf_evt | (ovrflw_o & ~clr_err_i);
      short_o  <= short_evt | (short_o & ~clr_err_i);
    end
  end

endmodule

// File: tb/tb_syn_adc_rx.sv
// Directed bench for syn_adc_rx: drives I2S slots on the pads and scoreboards the emitted frames.
module tb_syn_adc_rx;
  import syn_audio_pkg::*;

  localparam int S = 2;

  logic      clk = 1'b0;
  logic      rst, en, bclk, lrc, dat, ready, clr;
  bps_t      bps;
  pcm_data_t pcm_data;
  logic      valid, ovf, short_f;

  logic [63:0] exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  syn_adc_rx #(.SYNC_STAGES(S), .LRC_LEFT_LVL(1'b0)) dut (
    .clk_ir     (clk),
    .rst_ih     (rst),
    .en_i       (en),
    .bps_i      (bps),
    .adc_bclk_i (bclk),
    .adc_lrc_i  (lrc),
    .adc_dat_i  (dat),
    .pcm_data_o (pcm_data),
    .pcm_valid_o(valid),
    .pcm_ready_i(ready),
    .ovrflw_o   (ovf),
    .short_o    (short_f),
    .clr_err_i  (clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every accepted frame must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && valid && ready) begin
      n_cmp++;
      assert (exp_q.size() > 0) else begin
        n_bad++;
        $error("FAIL unexpected_frame: observed %h expected none", pcm_data);
      end
      if (exp_q.size() > 0) check("frame", pcm_data, exp_q.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic bclk_period(input logic l, input logic d);
    bclk = 1'b0; lrc = l; dat = d;
    repeat (3) @(posedge clk);
    #1 bclk = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Delay-slot bit is driven as 1 so a receiver that keeps it corrupts the word.
  task automatic drive_slot(input logic l, input logic [31:0] w, input int nb);
    bclk_period(l, 1'b1);
    for (int i = nb - 1; i >= 0; i--) bclk_period(l, w[i]);
  endtask

  task automatic resync(input bps_t b);
    @(posedge clk); #1 en = 1'b0;
    repeat (4) @(posedge clk);
    #1 bps = b; en = 1'b1;
    drive_slot(1'b1, 32'h0, 4);
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; bps = BPS_16; bclk = 1'b0; lrc = 1'b0; dat = 1'b0;
    ready = 1'b1; clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", valid, 0);
    check("rst_data", pcm_data, 0);
    check("rst_ovf", ovf, 0);
    check("rst_short", short_f, 0);
    rst = 1'b0;

    // 1: BPS_16 sign extension
    resync(BPS_16);
    drive_slot(1'b0, 32'h8001, 16);
    exp_q.push_back({32'hFFFF8001, 32'h00007FFF});
    drive_slot(1'b1, 32'h7FFF, 16);
    drive_slot(1'b0, 32'h0, 2);
    check("t1_short", short_f, 0);
    check("t1_ovf", ovf, 0);
    check("t1_drained", exp_q.size(), 0);

    // 2: BPS_32 exact words, then latency on the second frame
    resync(BPS_32);
    for (int f = 0; f < 2; f++) begin
      drive_slot(1'b0, 32'hDEADBEEF, 32);
      exp_q.push_back({32'hDEADBEEF, 32'h01234567});
      drive_slot(1'b1, 32'h01234567, 32);
    end
    bclk = 1'b0; lrc = 1'b0; dat = 1'b1;
    repeat (3) @(posedge clk);
    #1 bclk = 1'b1;
    for (int k = 1; k <= S + 3; k++) begin
      @(posedge clk); #1;
      if (k == S + 2) check("lat_before", valid, 0);
      if (k == S + 3) check("lat_at", valid, 1);
    end
    bclk_period(1'b0, 1'b0);
    check("t2_drained", exp_q.size(), 0);

    // 3: consumer stalled over two frames
    ready = 1'b0;
    resync(BPS_16);
    drive_slot(1'b0, 32'h1111, 16);
    exp_q.push_back({32'h00001111, 32'h00002222});
    drive_slot(1'b1, 32'h2222, 16);
    drive_slot(1'b0, 32'h8000, 16);
    drive_slot(1'b1, 32'h0001, 16);
    drive_slot(1'b0, 32'h0, 2);
    check("t3_valid_held", valid, 1);
    check("t3_data_held", pcm_data, {32'h00001111, 32'h00002222});
    check("t3_ovf_set", ovf, 1);
    pulse_clr();
    check("t3_ovf_clr", ovf, 0);
    ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("t3_valid_drop", valid, 0);
    check("t3_drained", exp_q.size(), 0);

    // 3b: ready arrives on the very cycle the next frame lands
    ready = 1'b0;
    resync(BPS_16);
    drive_slot(1'b0, 32'h1234, 16);
    exp_q.push_back({32'h00001234, 32'h00005678});
    drive_slot(1'b1, 32'h5678, 16);
    drive_slot(1'b0, 32'hFEDC, 16);
    exp_q.push_back({32'hFFFFFEDC, 32'h00000BA9});
    drive_slot(1'b1, 32'h0BA9, 16);
    bclk = 1'b0; lrc = 1'b0; dat = 1'b1;
    repeat (3) @(posedge clk);
    #1 bclk = 1'b1;
    for (int k = 1; k <= S + 3; k++) begin
      @(posedge clk); #1;
      if (k == S + 2) ready = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    check("t3b_ovf", ovf, 0);
    check("t3b_drained", exp_q.size(), 0);

    // 4: short 24-bit slots in BPS_32
    resync(BPS_32);
    drive_slot(1'b0, 32'hABCDEF, 24);
    exp_q.push_back({32'hABCDEF00, 32'h12345600});
    drive_slot(1'b1, 32'h123456, 24);
    drive_slot(1'b0, 32'h0, 2);
    check("t4_short_set", short_f, 1);
    pulse_clr();
    check("t4_short_clr", short_f, 0);

    // 4b: long slots in BPS_16; bps_i flips mid-frame and must not matter
    resync(BPS_16);
    drive_slot(1'b0, 32'hCAFEBABE, 32);
    bps = BPS_32;
    exp_q.push_back({32'hFFFFCAFE, 32'h00001234});
    drive_slot(1'b1, 32'h12345678, 32);
    drive_slot(1'b0, 32'h0, 2);
    check("t4b_short", short_f, 0);
    check("t4b_drained", exp_q.size(), 0);

    // 5: enable dropped inside a left word
    resync(BPS_16);
    bclk_period(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) bclk_period(1'b0, 1'b1);
    en = 1'b0;
    repeat (5) @(posedge clk);
    #1 en = 1'b1;
    for (int i = 0; i < 11; i++) bclk_period(1'b0, 1'b0);
    drive_slot(1'b1, 32'h5555, 16);
    drive_slot(1'b0, 32'h0F0F, 16);
    exp_q.push_back({32'h00000F0F, 32'hFFFF9999});
    drive_slot(1'b1, 32'h9999, 16);
    drive_slot(1'b0, 32'h0, 2);
    check("t5_drained", exp_q.size(), 0);

    // 6: async reset in the middle of a right word with a frame held
    ready = 1'b0;
    resync(BPS_16);
    drive_slot(1'b0, 32'h0102, 16);
    exp_q.push_back({32'h00000102, 32'h00000304});
    drive_slot(1'b1, 32'h0304, 16);
    drive_slot(1'b0, 32'h0506, 16);
    bclk_period(1'b1, 1'b1);
    for (int i = 0; i < 6; i++) bclk_period(1'b1, 1'b0);
    check("t6_valid_pre", valid, 1);
    #3 rst = 1'b1;
    #1;
    check("t6_valid_rst", valid, 0);
    check("t6_data_rst", pcm_data, 0);
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    ready = 1'b1;
    for (int i = 0; i < 10; i++) bclk_period(1'b1, 1'b1);
    drive_slot(1'b0, 32'h7E57, 16);
    exp_q.push_back({32'h00007E57, 32'h00001AB2});
    drive_slot(1'b1, 32'h1AB2, 16);
    drive_slot(1'b0, 32'h0, 2);
    repeat (10) @(posedge clk);
    #1;
    check("t6_drained", exp_q.size(), 0);
    check("t6_flags", {ovf, short_f}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
